// File: rtl/light_on_ctrl.sv
// light_on_ctrl: synchronized, debounced push-button toggles a run enable that gates a step-pulse divider; AUTO_OFF_EN adds a step-count timeout.
// Latency: clean btn rise -> on toggles DEBOUNCE_CYCLES+3 edges later; first step STEP_DIV cycles after on rises.
// Backpressure: none; on/step/btn_db are free-running registered outputs with no handshake.
module light_on_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned STEP_DIV        = 25000000,
   parameter int unsigned TIMEOUT_STEPS   = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic on,
   output logic step,
   output logic btn_db
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DIV_W = $clog2(STEP_DIV);

   // The counter never holds DEBOUNCE_CYCLES itself: the edge that would reach it accepts the level and clears.
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   typedef enum logic {
      S_OFF = 1'b0,
      S_RUN = 1'b1
   } state_t;

   logic             sync_q1;
   logic             sync_q2;
   logic [DB_W-1:0]  db_cnt;
   logic             btn_db_d;
   logic             press_evt;
   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic             div_wrap;
   logic             timeout;

   // Two-flop synchronizer: the only logic that touches the raw button.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= btn;
         sync_q2 <= sync_q1;
      end
   end

   // Debounce: count consecutive cycles of disagreement, accept the new level once the count is reached.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_d <= 1'b0;
      end else begin
         btn_db_d <= btn_db;
         if (sync_q2 == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            btn_db <= sync_q2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   // A press is the rising edge of the debounced level; releases are ignored.
   assign press_evt = btn_db & ~btn_db_d;
   assign div_wrap  = (div_cnt == DIV_LAST);

`ifdef AUTO_OFF_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_STEPS - 1);

   logic [7:0] to_cnt;

   // The run ends on the edge after the last permitted step pulse.
   assign timeout = step && (to_cnt == TO_LAST);

   // Count step pulses within a run; held at zero while off so every run starts fresh.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= 8'd0;
      end else if (state == S_OFF) begin
         to_cnt <= 8'd0;
      end else if (step) begin
         to_cnt <= to_cnt + 8'd1;
      end
   end
`else
   logic unused_timeout_cfg;

   // Runs end only by a press or reset in this build; the timeout length is folded into a sink.
   assign timeout            = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_STEPS;
`endif

   // Control FSM with registered on/step; the divider only runs in RUN and is parked at zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_OFF;
         on      <= 1'b0;
         step    <= 1'b0;
         div_cnt <= '0;
      end else begin
         case (state)
            S_OFF: begin
               step    <= 1'b0;
               div_cnt <= '0;
               if (press_evt) begin
                  state <= S_RUN;
                  on    <= 1'b1;
               end else begin
                  on    <= 1'b0;
               end
            end
            S_RUN: begin
               // A press coinciding with a timeout still lands in OFF: both leave RUN.
               if (press_evt || timeout) begin
                  state   <= S_OFF;
                  on      <= 1'b0;
                  step    <= 1'b0;
                  div_cnt <= '0;
               end else begin
                  on      <= 1'b1;
                  step    <= div_wrap;
                  div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
               end
            end
            default: begin
               state   <= S_OFF;
               on      <= 1'b0;
               step    <= 1'b0;
               div_cnt <= '0;
            end
         endcase
      end
   end

endmodule
